apb_req_master: RTL and testbench
=================================

# apb_req_master

Single-outstanding APB requester that converts a valid/ready request/response port into APB SETUP/ACCESS transfers. It drives a flat APB bus toward any APB completer, such as the register file slaves on the peripheral bus, and returns read data and error status on a buffered response channel. Configuration masters and test benches use it to reach APB register banks from non-APB logic.

## Interface
Parameters:
- AddrWidth, 32, APB address width (≥3)
- DataWidth, 32, APB data width, a multiple of 8
- TimeoutCycles, 32'd256, ACCESS-phase wait limit; used only with the timeout feature

Ports:
- pclk_i  in  1  clock
- preset_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted
- req_addr_i  in  AddrWidth  target address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DataWidth  write data
- req_strb_i  in  DataWidth/8  write strobes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  DataWidth  read data (0 for writes)
- rsp_err_o  out  1  pslverr or timeout
- paddr_o  out  AddrWidth  APB address
- pprot_o  out  3  fixed 3'b000
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB direction
- pwdata_o  out  DataWidth  APB write data
- pstrb_o  out  DataWidth/8  APB strobes (forced 0 on reads)
- pready_i  in  1  completer ready
- prdata_i  in  DataWidth  completer read data
- pslverr_i  in  1  completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready_o=1. On req_valid_i, register the address, write flag, data and strobes, then go to SETUP.
- SETUP: psel_o=1, penable_o=0. Go to ACCESS unconditionally.
- ACCESS: psel_o=1, penable_o=1.
  - On pready_i: capture prdata_i (0 if write) and pslverr_i, then go to RESP.
  - Otherwise hold ACCESS.
- RESP: rsp_valid_o=1, with rsp_rdata_o and rsp_err_o stable. On rsp_ready_i go to IDLE.
- req_ready_o is 0 in every state except IDLE. Only one transfer is outstanding at a time.
- paddr_o, pwrite_o, pwdata_o and pstrb_o come from registers and stay stable from SETUP through the last ACCESS cycle.
- APB address and data outputs may hold stale values when psel_o=0.
- pready_i, prdata_i and pslverr_i are ignored outside ACCESS.
- Reset values: state IDLE; psel_o, penable_o, pwrite_o and rsp_valid_o are 0; rsp_err_o, rsp_rdata_o, paddr_o, pwdata_o and pstrb_o are all 0.
- Reset mid-transfer returns to IDLE at once: psel_o and penable_o drop asynchronously, and the pending response is discarded.

## Timing
- Request handshake in cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2.
- With zero wait states, rsp_valid_o rises in cycle 3. Each APB wait state adds one cycle.
- If rsp_ready_i is held high, back-to-back requests take 4 cycles each: the RESP→IDLE cycle is the only bubble.
- No combinational path from any input to any output, apart from req_ready_o, which depends on state only.

## Configuration
- APB_REQ_MASTER_TIMEOUT_EN defined: a counter clears on SETUP entry and increments each ACCESS cycle without pready_i.
  - When it reaches TimeoutCycles-1 and pready_i is still low, the FSM leaves ACCESS for RESP with rsp_err_o=1 and rsp_rdata_o=0.
  - psel_o and penable_o drop in the next cycle.
  - pready_i in the same cycle as expiry wins: it is a normal completion.
- Undefined: no counter exists, and ACCESS waits indefinitely for pready_i. TimeoutCycles is unused.

## Structure
- Package apb_req_master_pkg holds:
  - state_e (IDLE/SETUP/ACCESS/RESP)
  - pprot default constant
  - parameterized req_t/rsp_t structs via typedef macros
- Sub-module apb_req_timeout, instantiated only under the macro, holds the clear/enable counter and produces a `expired` flag.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, strb 4'hF, with the completer ready immediately.
  - Expect psel_o in cycle 1, penable_o in cycle 2, pwrite_o=1 and paddr_o=0x10 through both.
  - Expect rsp_valid_o in cycle 3 with rsp_err_o=0 and rsp_rdata_o=0.
- Read addr 0x4, completer holds pready_i low for 3 cycles, then returns 0x12345678.
  - Expect 4 ACCESS cycles and rsp_rdata_o=0x12345678.
  - Expect pstrb_o=0 throughout.
- Read that completes with pslverr_i=1 → rsp_err_o=1. Hold rsp_ready_i low 5 cycles → response stays stable, req_ready_o=0.
- Assert preset_ni during ACCESS of a write → psel_o and penable_o go to 0 immediately; no rsp_valid_o after reset release.
- With APB_REQ_MASTER_TIMEOUT_EN and TimeoutCycles=8, pready_i never asserted → rsp_err_o=1 after 8 ACCESS cycles, and psel_o drops.
- Ten back-to-back random reads and writes with rsp_ready_i=1 → one transfer every 4 cycles, and every response matches a completer model.

Source files
------------

// File: rtl/apb_req_master_pkg.sv
// Shared types for apb_req_master: FSM state, APB protection default and
// request/response struct typedef macros sized by the instantiating module.
`ifndef APB_REQ_MASTER_PKG_SV
`define APB_REQ_MASTER_PKG_SV

`define APB_REQ_MASTER_TYPEDEF_REQ_T(name, AW, DW) \
   typedef struct packed { \
      logic [(AW)-1:0]     addr; \
      logic                write; \
      logic [(DW)-1:0]     wdata; \
      logic [(DW)/8-1:0]   strb; \
   } name;

`define APB_REQ_MASTER_TYPEDEF_RSP_T(name, DW) \
   typedef struct packed { \
      logic [(DW)-1:0]     rdata; \
      logic                err; \
   } name;

package apb_req_master_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StResp
   } state_e;

   localparam logic [2:0] PprotDefault = 3'b000;

endpackage

`endif

// File: rtl/apb_req_timeout.sv
// ACCESS-phase wait counter for apb_req_master; only built when
// APB_REQ_MASTER_TIMEOUT_EN is defined.
module apb_req_timeout
   import apb_req_master_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 32'd256
) (
   input  logic pclk_i,
   input  logic preset_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [31:0] LastCount = 32'(TimeoutCycles - 1);

   logic [31:0] r_cnt;

   always_ff @(posedge pclk_i or negedge preset_ni) begin
      if (!preset_ni) begin
         r_cnt <= '0;
      end else if (clr_i) begin
         r_cnt <= '0;
      end else if (en_i) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign expired_o = (r_cnt == LastCount);

endmodule

// File: rtl/apb_req_master.sv
// Single-outstanding valid/ready to APB requester. Optional ACCESS timeout is
// enabled by defining APB_REQ_MASTER_TIMEOUT_EN.
module apb_req_master
   import apb_req_master_pkg::*;
#(
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 32'd256
) (
   input  logic                   pclk_i,
   input  logic                   preset_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic                   req_write_i,
   input  logic [DataWidth-1:0]   req_wdata_i,
   input  logic [DataWidth/8-1:0] req_strb_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [DataWidth-1:0]   rsp_rdata_o,
   output logic                   rsp_err_o,
   output logic [AddrWidth-1:0]   paddr_o,
   output logic [2:0]             pprot_o,
   output logic                   psel_o,
   output logic                   penable_o,
   output logic                   pwrite_o,
   output logic [DataWidth-1:0]   pwdata_o,
   output logic [DataWidth/8-1:0] pstrb_o,
   input  logic                   pready_i,
   input  logic [DataWidth-1:0]   prdata_i,
   input  logic                   pslverr_i
);

   `APB_REQ_MASTER_TYPEDEF_REQ_T(req_t, AddrWidth, DataWidth)
   `APB_REQ_MASTER_TYPEDEF_RSP_T(rsp_t, DataWidth)

   state_e r_state;
   req_t   r_req;
   rsp_t   r_rsp;
   logic   r_psel;
   logic   r_penable;
   logic   r_rsp_valid;
   logic   w_expired;
   logic   w_done;

`ifdef APB_REQ_MASTER_TIMEOUT_EN
   logic w_cnt_clr;
   logic w_cnt_en;

   // Clearing throughout SETUP leaves the count at zero on the first ACCESS cycle.
   assign w_cnt_clr = (r_state == StSetup);
   assign w_cnt_en  = (r_state == StAccess) && !pready_i;

   apb_req_timeout #(
      .TimeoutCycles (TimeoutCycles)
   ) u_timeout (
      .pclk_i    (pclk_i),
      .preset_ni (preset_ni),
      .clr_i     (w_cnt_clr),
      .en_i      (w_cnt_en),
      .expired_o (w_expired)
   );
`else
   assign w_expired = 1'b0;
`endif

   assign w_done = pready_i || w_expired;

   always_ff @(posedge pclk_i or negedge preset_ni) begin
      if (!preset_ni) begin
         r_state     <= StIdle;
         r_req       <= '0;
         r_rsp       <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (req_valid_i) begin
                  r_req.addr  <= req_addr_i;
                  r_req.write <= req_write_i;
                  r_req.wdata <= req_wdata_i;
                  r_req.strb  <= req_write_i ? req_strb_i : '0;
                  r_psel      <= 1'b1;
                  r_state     <= StSetup;
               end
            end
            StSetup: begin
               r_penable <= 1'b1;
               r_state   <= StAccess;
            end
            StAccess: begin
               if (w_done) begin
                  // A completer ready in the expiry cycle still counts as completion.
                  if (pready_i) begin
                     r_rsp.rdata <= r_req.write ? '0 : prdata_i;
                     r_rsp.err   <= pslverr_i;
                  end else begin
                     r_rsp.rdata <= '0;
                     r_rsp.err   <= 1'b1;
                  end
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= StResp;
               end
            end
            StResp: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign req_ready_o = (r_state == StIdle);
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_rdata_o = r_rsp.rdata;
   assign rsp_err_o   = r_rsp.err;
   assign paddr_o     = r_req.addr;
   assign pprot_o     = PprotDefault;
   assign psel_o      = r_psel;
   assign penable_o   = r_penable;
   assign pwrite_o    = r_req.write;
   assign pwdata_o    = r_req.wdata;
   assign pstrb_o     = r_req.strb;

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: transaction-timeline model with a
// completer memory, per-cycle compare and directed literal checks.
module tb_apb_req_master;

   localparam int unsigned ToCycles = 8;
`ifdef APB_REQ_MASTER_TIMEOUT_EN
   localparam bit ToEn = 1'b1;
`else
   localparam bit ToEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_addr_i = '0;
   logic        req_write_i = 1'b0;
   logic [31:0] req_wdata_i = '0;
   logic [3:0]  req_strb_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic [31:0] paddr_o;
   logic [2:0]  pprot_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [31:0] pwdata_o;
   logic [3:0]  pstrb_o;
   logic        pready_i = 1'b0;
   logic [31:0] prdata_i = '0;
   logic        pslverr_i = 1'b0;

   apb_req_master #(
      .AddrWidth     (32),
      .DataWidth     (32),
      .TimeoutCycles (ToCycles)
   ) dut (
      .pclk_i      (clk),
      .preset_ni   (rst_n),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_write_i (req_write_i),
      .req_wdata_i (req_wdata_i),
      .req_strb_i  (req_strb_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .paddr_o     (paddr_o),
      .pprot_o     (pprot_o),
      .psel_o      (psel_o),
      .penable_o   (penable_o),
      .pwrite_o    (pwrite_o),
      .pwdata_o    (pwdata_o),
      .pstrb_o     (pstrb_o),
      .pready_i    (pready_i),
      .prdata_i    (prdata_i),
      .pslverr_i   (pslverr_i)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Completer memory model
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_5A5A);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   function automatic bit timed_out(input int w);
      return ToEn && (w > int'(ToCycles) - 1);
   endfunction

   function automatic int last_access(input int w);
      return timed_out(w) ? int'(ToCycles) - 1 : w;
   endfunction

   // Transaction timeline: age 1 is SETUP, age 2+k is the k-th ACCESS cycle.
   bit          m_active = 1'b0;
   bit          m_pending = 1'b0;
   int          m_age = 0;
   int          m_wait = 0;
   bit          m_err = 1'b0;
   bit          m_write = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_strb = '0;
   logic [31:0] m_rdata = '0;
   bit          m_rerr = 1'b0;
   int          m_hs_cyc = 0;
   int          cyc = 0;
   int          g_wait = 0;
   bit          g_err = 1'b0;

   always begin
      @(posedge clk);
      if (!rst_n) begin
         m_active  <= 1'b0;
         m_pending <= 1'b0;
      end else if (!m_active && !m_pending) begin
         if (req_valid_i) begin
            m_active <= 1'b1;
            m_age    <= 1;
            m_write  <= req_write_i;
            m_addr   <= req_addr_i;
            m_wdata  <= req_wdata_i;
            m_strb   <= req_strb_i;
            m_wait   <= g_wait;
            m_err    <= g_err;
            m_hs_cyc <= cyc;
         end
      end else if (m_active) begin
         if (m_age >= 2 && (m_age - 2) == last_access(m_wait)) begin
            m_active  <= 1'b0;
            m_pending <= 1'b1;
            if (timed_out(m_wait)) begin
               m_rdata <= '0;
               m_rerr  <= 1'b1;
            end else begin
               m_rdata <= m_write ? 32'h0 : mem_rd(m_addr);
               m_rerr  <= m_err;
               if (m_write && !m_err) mem[m_addr] = merge(mem_rd(m_addr), m_wdata, m_strb);
            end
         end else begin
            m_age <= m_age + 1;
         end
      end else if (rsp_ready_i) begin
         m_pending <= 1'b0;
      end
      cyc <= cyc + 1;
      #1;
      // Completer pins; junk where the requester must ignore them
      if (m_active && m_age == 1) begin
         pready_i  = 1'b1;
         pslverr_i = 1'b1;
         prdata_i  = $urandom;
      end else if (m_active) begin
         pready_i  = ((m_age - 2) == m_wait);
         prdata_i  = (pready_i && !m_write) ? mem_rd(m_addr) : $urandom;
         pslverr_i = pready_i ? m_err : 1'($urandom);
      end else begin
         pready_i  = 1'($urandom);
         prdata_i  = $urandom;
         pslverr_i = 1'($urandom);
      end
   end

   // Observations for directed literal checks, reset at each SETUP
   int          obs_access = 0;
   int          obs_lat = -1;
   logic [31:0] obs_rdata = '0;
   logic        obs_err = 1'b0;
   logic [3:0]  obs_strb_or = '0;
   logic [31:0] obs_paddr = '0;
   logic        obs_pwrite = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("req_ready", {31'b0, req_ready_o}, {31'b0, !m_active && !m_pending});
         chk("psel", {31'b0, psel_o}, {31'b0, m_active});
         chk("penable", {31'b0, penable_o}, {31'b0, m_active && m_age >= 2});
         chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, m_pending});
         chk("pprot", {29'b0, pprot_o}, 32'h0);
         if (m_pending) begin
            chk("rsp_rdata", rsp_rdata_o, m_rdata);
            chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, m_rerr});
         end
         if (m_active) begin
            chk("paddr", paddr_o, m_addr);
            chk("pwrite", {31'b0, pwrite_o}, {31'b0, m_write});
            chk("pstrb", {28'b0, pstrb_o}, {28'b0, m_write ? m_strb : 4'h0});
            if (m_write) chk("pwdata", pwdata_o, m_wdata);
         end
         if (m_active && m_age == 1) begin
            obs_access  = 0;
            obs_lat     = -1;
            obs_strb_or = '0;
         end
         if (psel_o) begin
            obs_strb_or = obs_strb_or | pstrb_o;
            obs_paddr   = paddr_o;
            obs_pwrite  = pwrite_o;
         end
         if (psel_o && penable_o) obs_access++;
         if (rsp_valid_o && obs_lat < 0) begin
            obs_lat   = cyc - m_hs_cyc;
            obs_rdata = rsp_rdata_o;
            obs_err   = rsp_err_o;
         end
      end
   end

   task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int wt, input bit err, input int hold,
                         output int hs);
      bit got = 1'b0;
      int pc = 0;
      hs = -1;
      g_wait      = wt;
      g_err       = err;
      req_write_i = wr;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      req_strb_i  = strb;
      req_valid_i = 1'b1;
      rsp_ready_i = (hold == 0);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (m_active && m_age == 1) begin
            got = 1'b1;
            break;
         end
      end
      req_valid_i = 1'b0;
      req_addr_i  = ~addr;
      req_wdata_i = ~wdata;
      if (!got) begin
         chk("handshake_wait", 32'h0, 32'h1);
         return;
      end
      hs  = m_hs_cyc;
      got = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (!m_active && !m_pending) begin
            got = 1'b1;
            break;
         end
         if (m_pending) begin
            if (pc >= hold) rsp_ready_i = 1'b1;
            pc++;
         end
         @(posedge clk);
         #1;
      end
      if (!got) chk("response_wait", 32'h0, 32'h1);
   endtask

   initial begin
      int hs;
      int prev_hs;
      mem[32'h4] = 32'h1234_5678;

      #1 rst_n = 1'b0;
      #1;
      chk("rst_psel", {31'b0, psel_o}, 32'h0);
      chk("rst_penable", {31'b0, penable_o}, 32'h0);
      chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
      chk("rst_rsp_err", {31'b0, rsp_err_o}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
      chk("rst_paddr", paddr_o, 32'h0);
      chk("rst_pwdata", pwdata_o, 32'h0);
      chk("rst_pstrb", {28'b0, pstrb_o}, 32'h0);
      chk("rst_pwrite", {31'b0, pwrite_o}, 32'h0);
      chk("rst_req_ready", {31'b0, req_ready_o}, 32'h1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Zero-wait write
      do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0, hs);
      chk("wr_rsp_latency", obs_lat, 32'd3);
      chk("wr_access_cycles", obs_access, 32'd1);
      chk("wr_paddr", obs_paddr, 32'h10);
      chk("wr_pwrite", {31'b0, obs_pwrite}, 32'h1);
      chk("wr_rsp_rdata", obs_rdata, 32'h0);
      chk("wr_rsp_err", {31'b0, obs_err}, 32'h0);

      // Read with three wait states
      do_req(1'b0, 32'h4, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 0, hs);
      chk("rd_access_cycles", obs_access, 32'd4);
      chk("rd_rsp_rdata", obs_rdata, 32'h1234_5678);
      chk("rd_pstrb_zero", {28'b0, obs_strb_or}, 32'h0);
      chk("rd_rsp_latency", obs_lat, 32'd6);

      // Slave error, response held off for five cycles
      do_req(1'b0, 32'h8, 32'h0, 4'h0, 1, 1'b1, 5, hs);
      chk("err_rsp_err", {31'b0, obs_err}, 32'h1);
      chk("err_rsp_rdata", obs_rdata, 32'h0000_8 ^ 32'hA5A5_5A5A);

      // Reset during ACCESS of a write
      g_wait      = 6;
      g_err       = 1'b0;
      req_write_i = 1'b1;
      req_addr_i  = 32'h20;
      req_wdata_i = 32'h0BAD_F00D;
      req_strb_i  = 4'hF;
      req_valid_i = 1'b1;
      rsp_ready_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (m_active && m_age == 1) req_valid_i = 1'b0;
         if (m_active && m_age == 2) break;
      end
      req_valid_i = 1'b0;
      chk("mid_penable_before_rst", {31'b0, penable_o}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_psel", {31'b0, psel_o}, 32'h0);
      chk("mid_rst_penable", {31'b0, penable_o}, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_rsp_valid", {31'b0, rsp_valid_o}, 32'h0);
      chk("post_rst_req_ready", {31'b0, req_ready_o}, 32'h1);

`ifdef APB_REQ_MASTER_TIMEOUT_EN
      // Completer never ready
      do_req(1'b0, 32'hC, 32'h0, 4'h0, 1000, 1'b0, 0, hs);
      chk("to_access_cycles", obs_access, ToCycles);
      chk("to_rsp_err", {31'b0, obs_err}, 32'h1);
      chk("to_rsp_rdata", obs_rdata, 32'h0);
      chk("to_rsp_latency", obs_lat, ToCycles + 2);
`endif

      // Back-to-back mixed traffic
      prev_hs = -1;
      for (int i = 0; i < 10; i++) begin
         bit          wr = 1'($urandom);
         logic [31:0] a  = {28'b0, 2'($urandom), 2'b00};
         do_req(wr, a, $urandom, 4'($urandom), 0, ($urandom_range(0, 3) == 0), 0, hs);
         if (i > 0) chk("b2b_spacing", hs - prev_hs, 32'd4);
         prev_hs = hs;
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
